if_stage: RTL

- Instruction fetch stage. Sits directly upstream of the decode stage and supplies its instruction word and PC.
- Generates sequential PCs from a boot address and issues requests to instruction memory over a req/gnt/rvalid handshake.
- Buffers returned words in a small prefetch FIFO and presents them to decode through a registered valid/ready interface.
- Handles branch/jump redirects by flushing the FIFO and discarding responses that are still in flight.

---
 rtl/if_stage_if.sv | 25 ++
 rtl/if_stage.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/if_stage_if.sv
// Instruction memory request/response bundle between the fetch stage (master)
// and instruction memory (slave).
interface if_stage_if;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i;
  logic        instr_rvalid_i;
  logic [31:0] instr_rdata_i;

  modport master (
    output instr_req_o,
    output instr_addr_o,
    input  instr_gnt_i,
    input  instr_rvalid_i,
    input  instr_rdata_i
  );

  modport slave (
    input  instr_req_o,
    input  instr_addr_o,
    output instr_gnt_i,
    output instr_rvalid_i,
    output instr_rdata_i
  );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: sequential PC generation, req/gnt/rvalid fetch,
// prefetch FIFO, registered output to decode and redirect with in-flight discard.
module if_stage #(
  parameter logic [31:0] BOOT_ADDR       = 32'h0000_0080,
  parameter int          FIFO_DEPTH      = 2,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  if_stage_if.master  mem,
  input  logic        branch_i,
  input  logic [31:0] branch_target_i,
  input  logic        id_ready_i,
  output logic        instr_valid_id_o,
  output logic [31:0] instr_rdata_id_o,
  output logic [31:0] pc_id_o
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int OCC_W = CNT_W + 1;
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]      fetch_pc;
  logic [31:0]      addr_q;
  logic             held_q;
  logic             stale_q;
  logic             run_q;
  logic [OUT_W-1:0] outstanding;
  logic [OUT_W-1:0] discard;
  logic [31:0]      resp_pc;

  logic [31:0]      fifo_data [FIFO_DEPTH];
  logic [31:0]      fifo_pc   [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] fifo_count;

  logic             valid_q;
  logic [31:0]      rdata_q;
  logic [31:0]      pc_q;

  logic [31:0]      target;
  logic             req;
  logic             gnt_fire;
  logic             rvalid;
  logic             drop;
  logic             fifo_push;
  logic             fifo_pop;
  logic             out_load;
  logic [OCC_W-1:0] occupancy;
  logic [OUT_W-1:0] outstanding_nxt;

  assign target   = branch_target_i & 32'hFFFF_FFFC;
  assign rvalid   = mem.instr_rvalid_i;
  assign gnt_fire = req && mem.instr_gnt_i;
  assign drop     = rvalid && (discard != '0);

  assign out_load  = (fifo_count != '0) && (!valid_q || id_ready_i);
  assign fifo_push = rvalid && !drop && !branch_i;
  assign fifo_pop  = out_load && !branch_i;

  // The entry leaving for the output register this cycle frees its slot, which
  // lets a granted-every-cycle memory sustain one instruction per cycle.
  assign occupancy = OCC_W'(fifo_count) - OCC_W'(out_load) + OCC_W'(outstanding);
  assign req       = run_q && (held_q ||
                     ((occupancy < OCC_W'(FIFO_DEPTH)) &&
                      (outstanding < OUT_W'(MAX_OUTSTANDING))));

  assign outstanding_nxt = outstanding + OUT_W'(gnt_fire) - OUT_W'(rvalid);

  assign mem.instr_req_o  = req;
  assign mem.instr_addr_o = held_q ? addr_q : fetch_pc;

  // A stale request was already on the bus when a redirect arrived: it must
  // complete unchanged, its response is dropped and it does not advance fetch_pc.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      run_q       <= 1'b0;
      held_q      <= 1'b0;
      stale_q     <= 1'b0;
      addr_q      <= BOOT_ADDR;
      fetch_pc    <= BOOT_ADDR;
      outstanding <= '0;
      discard     <= '0;
      resp_pc     <= BOOT_ADDR;
    end else begin
      run_q       <= 1'b1;
      held_q      <= req && !mem.instr_gnt_i;
      stale_q     <= req && !mem.instr_gnt_i && (stale_q || branch_i);
      addr_q      <= mem.instr_addr_o;
      outstanding <= outstanding_nxt;
      if (branch_i) begin
        fetch_pc <= target;
        discard  <= outstanding_nxt;
        resp_pc  <= target;
      end else begin
        if (gnt_fire && !stale_q) fetch_pc <= fetch_pc + 32'd4;
        discard <= discard - OUT_W'(drop) + OUT_W'(gnt_fire && stale_q);
        if (fifo_push) resp_pc <= resp_pc + 32'd4;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else if (branch_i) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (fifo_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (fifo_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      fifo_count <= fifo_count + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (fifo_push) begin
      fifo_data[wr_ptr] <= mem.instr_rdata_i;
      fifo_pc[wr_ptr]   <= resp_pc;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      rdata_q <= NOP;
      pc_q    <= '0;
    end else if (branch_i) begin
      valid_q <= 1'b0;
    end else if (out_load) begin
      valid_q <= 1'b1;
      rdata_q <= fifo_data[rd_ptr];
      pc_q    <= fifo_pc[rd_ptr];
    end else if (id_ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign instr_valid_id_o = valid_q;
  assign instr_rdata_id_o = rdata_q;
  assign pc_id_o          = pc_q;

  fifo_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(fifo_push && !fifo_pop && (fifo_count == CNT_W'(FIFO_DEPTH))));
  fifo_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(fifo_pop && (fifo_count == '0)));

endmodule
